data_memory: RTL and testbench

- Byte-addressed data memory for the 8-bit single-cycle CPU; responder to the CPU's load/store requests.
- Ports are the other end of the CPU memory interface: the CPU issues READ or WRITE; this block stalls it with BUSYWAIT for a fixed multi-cycle latency, then completes the access.
- Sits beside the register file. Load data returns to the register-file write port; store data comes from a register-file read port.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 29 ++
 rtl/data_memory.sv | 106 ++++++++++
 tb/tb_data_memory.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and defaults for the CPU data memory.
package dmem_pkg;

  // Default number of clock edges from request acceptance to commit.
  localparam int unsigned DEFAULT_LATENCY = 5;

  // Counter must hold LATENCY-1 for the largest legal latency (15).
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/dmem_array.sv
// Byte storage: synchronous write, asynchronous read, async active-low clear.
module dmem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear every entry on reset; otherwise write the addressed byte when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory responding to CPU load/store requests with BUSYWAIT.
module data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (CLK),
    .rst_n (RESET),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // State, countdown, request latches and load result register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in ACCESS, commit at count 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (READ || WRITE) begin
          // A simultaneous READ and WRITE is taken as a store.
          op_d    = WRITE ? OP_WRITE : OP_READ;
          addr_d  = ADDRESS;
          wdata_d = WRITEDATA;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          if (op_q == OP_WRITE) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_rdata;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign READDATA = rdata_q;
  // Gated by RESET so the stall drops while reset is held even with a request up.
  assign BUSYWAIT = RESET &&
                    (((state_q == S_IDLE) && (READ || WRITE)) || (state_q == S_ACCESS));

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory at LATENCY=5 and LATENCY=2.
module tb_data_memory;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       rd0, wr0, rd1, wr1;
  logic [7:0] a0, d0, a1, d1;
  logic [7:0] q0, q1;
  logic       bw0, bw1;

  int vectors    = 0;
  int miscompares = 0;
  int edge_cnt   = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  data_memory #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .LATENCY (5)
  ) dut5 (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (rd0),
    .WRITE     (wr0),
    .ADDRESS   (a0),
    .WRITEDATA (d0),
    .READDATA  (q0),
    .BUSYWAIT  (bw0)
  );

  data_memory #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .LATENCY (2)
  ) dut2 (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (rd1),
    .WRITE     (wr1),
    .ADDRESS   (a1),
    .WRITEDATA (d1),
    .READDATA  (q1),
    .BUSYWAIT  (bw1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int s, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    if (s == 0) begin
      rd0 = r; wr0 = w; a0 = a; d0 = d;
    end else begin
      rd1 = r; wr1 = w; a1 = a; d1 = d;
    end
  endtask

  function automatic logic busy(input int s);
    return (s == 0) ? bw0 : bw1;
  endfunction

  function automatic logic [7:0] rdat(input int s);
    return (s == 0) ? q0 : q1;
  endfunction

  // One complete request: stall seen at once, LATENCY stalled edges, result in DONE.
  task automatic do_op(input int s, input int lat, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input bit chg, input string tag);
    int n;
    n = 0;
    set_req(s, r, w, a, d);
    #1;
    chk({tag, "_busy_now"}, 32'(busy(s)), 32'd1);
    while (busy(s) === 1'b1 && n < 40) begin
      tick();
      n++;
      if (chg && n == 2) set_req(s, r, w, a + 8'd1, 8'hFF);
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_rdata"}, 32'(rdat(s)), 32'(exp_rd));
    set_req(s, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk({tag, "_idle"}, 32'(busy(s)), 32'd0);
  endtask

  // Two stores at the address extremes, then a held READ across both.
  task automatic b2b(input int s, input int lat, input logic [7:0] prev, input string tag);
    int n;
    int c1;
    do_op(s, lat, 1'b0, 1'b1, 8'h00, 8'h01, prev, 1'b0, {tag, "_wr00"});
    do_op(s, lat, 1'b0, 1'b1, 8'hFF, 8'hFE, prev, 1'b0, {tag, "_wrFF"});
    set_req(s, 1'b1, 1'b0, 8'h00, 8'h00);
    n = 0;
    #1;
    while (busy(s) === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_rd00_latency"}, 32'(n), 32'(lat));
    chk({tag, "_rd00_rdata"}, 32'(rdat(s)), 32'h01);
    c1 = edge_cnt;
    set_req(s, 1'b1, 1'b0, 8'hFF, 8'h00);
    tick();
    chk({tag, "_done_one_cycle"}, 32'(busy(s)), 32'd1);
    n = 0;
    while (busy(s) === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_rdFF_rdata"}, 32'(rdat(s)), 32'hFE);
    chk({tag, "_commit_spacing"}, 32'(edge_cnt - c1), 32'(lat + 1));
    set_req(s, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  initial begin
    RESET = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    chk("por_rdata", 32'(q0), 32'h00);
    chk("por_busy", 32'(bw0), 32'd0);
    tick();
    tick();
    RESET = 1'b1;
    tick();

    do_op(0, 5, 1'b1, 1'b0, 8'h33, 8'h00, 8'h00, 1'b0, "rd33_after_por");
    do_op(0, 5, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, "wr10");
    do_op(0, 5, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, "rd10");

    // Reset with a request pending in IDLE.
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    chk("pre_rst_busy", 32'(bw0), 32'd1);
    RESET = 1'b0;
    #1;
    chk("rst_busy", 32'(bw0), 32'd0);
    chk("rst_rdata", 32'(q0), 32'h00);
    tick();
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    RESET = 1'b1;
    tick();
    do_op(0, 5, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, "rd10_cleared");

    // Input changes during ACCESS are ignored.
    do_op(0, 5, 1'b0, 1'b1, 8'h20, 8'h3C, 8'h00, 1'b1, "wr20_chg");
    do_op(0, 5, 1'b1, 1'b0, 8'h21, 8'h00, 8'h00, 1'b0, "rd21");
    do_op(0, 5, 1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, "rd20");

    // READ and WRITE together act as a store; READDATA keeps 0x3C.
    do_op(0, 5, 1'b1, 1'b1, 8'h05, 8'h77, 8'h3C, 1'b0, "rw05");
    do_op(0, 5, 1'b1, 1'b0, 8'h05, 8'h00, 8'h77, 1'b0, "rd05");

    // Reset on the third edge of a write aborts it.
    set_req(0, 1'b0, 1'b1, 8'h40, 8'h99);
    tick();
    tick();
    tick();
    chk("mid_busy_before_rst", 32'(bw0), 32'd1);
    RESET = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bw0), 32'd0);
    chk("mid_rst_rdata", 32'(q0), 32'h00);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    RESET = 1'b1;
    tick();
    do_op(0, 5, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b0, "rd40_aborted");

    b2b(0, 5, 8'h00, "lat5");
    b2b(1, 2, 8'h00, "lat2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
